// File: rtl/matrix_scan.sv
// matrix_scan: double-buffered 8x8 LED matrix scanner with dwell/blank timing.
module matrix_scan #(
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        on_i,
  input  logic [63:0] frame_in_i,
  input  logic        frame_valid_i,
  output logic        frame_ready_o,
  output logic [7:0]  row_sel_o,
  output logic [7:0]  col_data_o,
  output logic        frame_done_o
);
  localparam int CMAX = DWELL > BLANK ? DWELL : BLANK;
  localparam int CW = $clog2(CMAX) + 1;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHOW, S_BLANK} state_e;
  state_e          state_q, state_d;
  logic [2:0]      r_q, r_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [63:0]     pend_q, pend_d, act_q, act_d;
  logic            full_q, full_d, have_q, have_d;
  logic            ready_q, done_q, done_d;
  logic [7:0]      row_q, row_d, col_q, col_d;
  logic            accept;
  assign accept = frame_valid_i && !full_q;
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    act_d   = act_q;
    full_d  = full_q;
    have_d  = have_q;
    if (accept) begin
      pend_d = frame_in_i;
      full_d = 1'b1;
    end
    case (state_q)
      S_IDLE: if (full_q || have_q) state_d = S_LOAD;
      S_LOAD: begin
        if (full_q) begin
          act_d  = pend_q;
          full_d = 1'b0;
          have_d = 1'b1;
        end
        r_d     = 3'd0;
        cnt_d   = '0;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DWELL - 1)) begin
          cnt_d = '0;
          if (BLANK > 0) state_d = S_BLANK;
          else if (r_q == 3'd7) state_d = S_LOAD;
          else r_d = r_q + 3'd1;
        end
      end
      S_BLANK: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(BLANK - 1)) begin
          cnt_d = '0;
          if (r_q == 3'd7) state_d = S_LOAD;
          else begin
            r_d     = r_q + 3'd1;
            state_d = S_SHOW;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!on_i) state_d = S_IDLE;
    // Outputs are registered from next state so they line up with the state they describe.
    row_d  = state_d == S_SHOW ? 8'd1 << r_d : 8'd0;
    col_d  = state_d == S_SHOW ? act_d[{~r_d, 3'b111} -: 8] : 8'd0;
    done_d = state_d == S_LOAD && state_q != S_IDLE;
  end
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
      act_q   <= '0;
      full_q  <= 1'b0;
      have_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      full_q  <= full_d;
      have_q  <= have_d;
      ready_q <= !full_d;
      done_q  <= done_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end
  assign frame_ready_o = ready_q;
  assign row_sel_o     = row_q;
  assign col_data_o    = col_q;
  assign frame_done_o  = done_q;
endmodule

// File: tb/tb_matrix_scan.sv
// tb_matrix_scan: checks two scanner configurations against a frame-timeline model.
module tb_matrix_scan;
  logic clk, rst_n, on, valid;
  logic [63:0] din;
  logic rdy0, done0, rdy1, done1;
  logic [7:0] row0, col0, row1, col1;
  int n_cmp = 0, n_bad = 0, cyc = 0;

  matrix_scan #(.DWELL(4), .BLANK(1)) u0 (
    .clk_i(clk), .reset_ni(rst_n), .on_i(on), .frame_in_i(din), .frame_valid_i(valid),
    .frame_ready_o(rdy0), .row_sel_o(row0), .col_data_o(col0), .frame_done_o(done0));
  matrix_scan #(.DWELL(1), .BLANK(0)) u1 (
    .clk_i(clk), .reset_ni(rst_n), .on_i(on), .frame_in_i(din), .frame_valid_i(valid),
    .frame_ready_o(rdy1), .row_sel_o(row1), .col_data_o(col1), .frame_done_o(done1));

  initial clk = 0;
  always #5 clk = ~clk;

  // Model: position t within a frame of period 1+8*(D+B); t=0 is the load cycle.
  typedef struct {
    bit [63:0] pend, act;
    bit full, have, run, first;
    int t;
  } m_t;
  m_t m0, m1;

  function automatic m_t mreset();
    m_t s;
    s.pend = 0; s.act = 0; s.full = 0; s.have = 0; s.run = 0; s.first = 0; s.t = 0;
    return s;
  endfunction

  function automatic m_t mstep(m_t s, bit o, bit v, logic [63:0] d, int dw, int bl);
    m_t n = s;
    int p = 1 + 8 * (dw + bl);
    if (!s.run) begin
      if (o && (s.full || s.have)) begin n.run = 1; n.t = 0; n.first = 1; end
    end else begin
      if (s.t == 0 && s.full) begin n.act = s.pend; n.full = 0; n.have = 1; end
      if (s.t == 0) n.first = 0;
      if (!o) n.run = 0;
      else n.t = (s.t + 1) % p;
    end
    if (v && !s.full) begin n.pend = d; n.full = 1; end
    return n;
  endfunction

  function automatic bit mshow(m_t s, int dw, int bl);
    return s.run && s.t != 0 && ((s.t - 1) % (dw + bl)) < dw;
  endfunction

  function automatic logic [7:0] mrow(m_t s, int dw, int bl);
    return mshow(s, dw, bl) ? 8'd1 << ((s.t - 1) / (dw + bl)) : 8'd0;
  endfunction

  function automatic logic [7:0] mcol(m_t s, int dw, int bl);
    int r = (s.t - 1) / (dw + bl);
    return mshow(s, dw, bl) ? s.act[63 - 8 * r -: 8] : 8'd0;
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m0 <= mreset();
      m1 <= mreset();
    end else begin
      m0 <= mstep(m0, on, valid, din, 4, 1);
      m1 <= mstep(m1, on, valid, din, 1, 0);
    end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  always @(negedge clk)
    if (cyc >= 2) begin
      chk("row0", 64'(row0), 64'(mrow(m0, 4, 1)));
      chk("col0", 64'(col0), 64'(mcol(m0, 4, 1)));
      chk("done0", 64'(done0), 64'(m0.run && m0.t == 0 && !m0.first));
      chk("rdy0", 64'(rdy0), 64'(!m0.full));
      chk("onehot0", 64'($countones(row0) <= 1), 64'd1);
      chk("row1", 64'(row1), 64'(mrow(m1, 1, 0)));
      chk("col1", 64'(col1), 64'(mcol(m1, 1, 0)));
      chk("done1", 64'(done1), 64'(m1.run && m1.t == 0 && !m1.first));
      chk("rdy1", 64'(rdy1), 64'(!m1.full));
      chk("onehot1", 64'($countones(row1) <= 1), 64'd1);
    end

  task automatic send(input logic [63:0] d);
    int n = 0;
    valid = 1; din = d;
    while (!rdy0 && n < 300) begin @(negedge clk); n++; end
    chk("send_timeout", 64'(n < 300), 64'd1);
    @(negedge clk);
    valid = 0;
  endtask

  task automatic wait_row0(input logic [7:0] v);
    int n = 0;
    while (row0 !== v && n < 300) begin @(negedge clk); n++; end
    chk("wait_row0", 64'(row0), 64'(v));
  endtask

  task automatic wait_done(input bit which, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!(which ? done1 : done0) && n < 300);
  endtask

  logic [7:0] a_rows [8];
  logic [63:0] fr;
  int n;

  initial begin
    a_rows = '{8'h04, 8'h12, 8'h64, 8'h24, 8'h00, 8'h34, 8'h3C, 8'h28};
    rst_n = 0; on = 0; valid = 0; din = 0;
    repeat (3) @(negedge clk);
    rst_n = 1; on = 1;
    repeat (10) @(negedge clk);
    chk("idle_row", 64'(row0), 64'h00);
    chk("idle_ready", 64'(rdy0), 64'd1);
    // Frame A: exact row contents, dwell 4 then one blank cycle per row.
    send(64'h0412_6424_0034_3C28);
    wait_row0(8'h01);
    for (int r = 0; r < 8; r++) begin
      for (int d = 0; d < 4; d++) begin
        chk("a_row", 64'(row0), 64'(8'd1 << r));
        chk("a_col", 64'(col0), 64'(a_rows[r]));
        @(negedge clk);
      end
      chk("a_blank", 64'(row0), 64'h00);
      @(negedge clk);
    end
    chk("a_done", 64'(done0), 64'd1);
    wait_done(0, n);
    chk("period41", 64'(n), 64'd41);
    // Frame B arrives during row 3 and must not tear the current frame.
    wait_row0(8'h08);
    send(64'hFFFF_0000_FFFF_0000);
    chk("b_ready_low", 64'(rdy0), 64'd0);
    wait_row0(8'h80);
    chk("a_row7_kept", 64'(col0), 64'h28);
    chk("b_still_pending", 64'(rdy0), 64'd0);
    wait_row0(8'h01);
    chk("b_row0", 64'(col0), 64'hFF);
    chk("b_ready_high", 64'(rdy0), 64'd1);
    // C then D back to back: D stalls until C is loaded.
    send(64'h0102_0408_1020_4080);
    chk("stall_ready", 64'(rdy0), 64'd0);
    send(64'hA5A5_5A5A_C3C3_3C3C);
    chk("c_row0_sel", 64'(row0), 64'h01);
    chk("c_row0", 64'(col0), 64'h01);
    wait_done(0, n);
    @(negedge clk);
    chk("d_row0", 64'(col0), 64'hA5);
    // Scan disable mid-frame and restart.
    wait_row0(8'h20);
    on = 0;
    @(negedge clk);
    chk("off_row", 64'(row0), 64'h00);
    chk("off_col", 64'(col0), 64'h00);
    repeat (3) @(negedge clk);
    on = 1;
    @(negedge clk);
    chk("restart_no_done", 64'(done0), 64'd0);
    @(negedge clk);
    chk("restart_row", 64'(row0), 64'h01);
    chk("restart_col", 64'(col0), 64'hA5);
    // Async reset with a pending frame discards it.
    send(64'h1111_2222_3333_4444);
    wait_row0(8'h04);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_row", 64'(row0), 64'h00);
    chk("rst_col", 64'(col0), 64'h00);
    chk("rst_ready", 64'(rdy0), 64'd1);
    @(negedge clk);
    rst_n = 1;
    repeat (20) @(negedge clk);
    chk("post_rst_idle", 64'(row0), 64'h00);
    chk("post_rst_ready", 64'(rdy0), 64'd1);
    fr = 64'h8142_2418_1824_4281;
    send(fr);
    wait_row0(8'h01);
    chk("f_row0", 64'(col0), 64'h81);
    // DWELL=1, BLANK=0: rows on consecutive cycles, 9-cycle frame.
    wait_done(1, n);
    chk("u1_done_seen", 64'(done1), 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("u1_row", 64'(row1), 64'(8'd1 << i));
      chk("u1_col", 64'(col1), 64'(fr[63 - 8 * i -: 8]));
    end
    @(negedge clk);
    chk("u1_period9", 64'(done1), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
